// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   uart_state_t    - receiver FSM state encoding (3-bit)
//   UART_DATA_BITS  - payload bits per frame
//   UART_IDLE_LEVEL - line level while no frame is in flight
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input pin.
// Ports:
//   clk_from_FPGA  in  - destination clock
//   rst_from_FPGA  in  - asynchronous active-low reset, loads RESET_VAL
//   async_in       in  - asynchronous input
//   sync_out       out - input retimed into the clk_from_FPGA domain (2-cycle latency)
// Parameter RESET_VAL sets the value both flops take in reset (default 1,
// matching an idle-high line).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_from_FPGA,
    input  logic rst_from_FPGA,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first) with a valid/ready holding register.
// Bit timing is derived from a per-bit clock count (CLKS_PER_BIT core clocks).
// Ports:
//   clk_from_FPGA         in   core clock, rising edge
//   rst_from_FPGA         in   asynchronous active-low reset
//   uart_rx_pin_for_FPGA  in   raw serial line (idle high, asynchronous)
//   rx_data               out  last received byte
//   rx_valid              out  rx_data holds an unconsumed byte
//   rx_ready              in   consumer accepts when rx_valid && rx_ready
//   rx_frame_err          out  1-cycle pulse: stop bit sampled low
//   rx_overrun            out  1-cycle pulse: unconsumed byte overwritten
//   rx_busy               out  FSM not in IDLE
//   rx_parity_err         out  (UART_RX_PARITY_EN only) 1-cycle pulse on bad even parity
// Build option: define UART_RX_PARITY_EN for 8E1 frames (parity state + rx_parity_err).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk_from_FPGA,
    input  logic       rst_from_FPGA,
    input  logic       uart_rx_pin_for_FPGA,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_cpb
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
        if (DATA_BITS != UART_DATA_BITS) begin : g_bad_bits
            $error("uart_rx: DATA_BITS is fixed at 8");
        end
    endgenerate

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rxs;

    sync_2ff #(
        .RESET_VAL(UART_IDLE_LEVEL)
    ) u_sync (
        .clk_from_FPGA (clk_from_FPGA),
        .rst_from_FPGA (rst_from_FPGA),
        .async_in      (uart_rx_pin_for_FPGA),
        .sync_out      (rxs)
    );

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic             ovr_q,   ovr_d;
    logic             stop_ok;
    logic             stop_bad;
`ifdef UART_RX_PARITY_EN
    logic             par_q,   par_d;
    logic             perr_q,  perr_d;
`endif

    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Frame FSM: next state, counters and shift register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Re-check the line mid start bit so short glitches are rejected.
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        stop_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // Wait out a held-low line so it cannot look like new start bits.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Holding register: a fresh byte wins over an accept in the same cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        ferr_d  = stop_bad;
        if (stop_ok) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !rx_ready;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
`ifdef UART_RX_PARITY_EN
        perr_d = (stop_ok || stop_bad) && (^{shreg_q, par_q});
`endif
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
    assign rx_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT = 8.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_from_FPGA        (clk),
        .rst_from_FPGA        (rst_n),
        .uart_rx_pin_for_FPGA (pin),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .rx_ready             (rx_ready),
        .rx_frame_err         (rx_frame_err),
        .rx_overrun           (rx_overrun),
        .rx_busy              (rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err        (rx_parity_err)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int valid_cyc, hs_cnt, ferr_cnt, ovr_cnt, busy_seen, perr_cnt, perr_valid_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        valid_cyc      = 0;
        hs_cnt         = 0;
        ferr_cnt       = 0;
        ovr_cnt        = 0;
        busy_seen      = 0;
        perr_cnt       = 0;
        perr_valid_cnt = 0;
    endtask

    task automatic drive_bit(input logic v);
        pin = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        pin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(stop_bit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par_bit);
        drive_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par_bit);
        drive_bit(1'b1);
    endtask
`endif

    // Monitor: sample mid-cycle, retire scoreboard entries on each handshake.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (rx_valid)     valid_cyc++;
                if (rx_busy)      busy_seen++;
                if (rx_frame_err) ferr_cnt++;
                if (rx_overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
                if (rx_parity_err)             perr_cnt++;
                if (rx_parity_err && rx_valid) perr_valid_cnt++;
`endif
                if (rx_valid && rx_ready) begin
                    hs_cnt++;
                    check("sb_pending", 32'(exp_q.size()), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        check("sb_data", {24'h0, rx_data}, {24'h0, exp_b});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_counts();
        rst_n    = 1'b0;
        pin      = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'h0, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy}, 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Single byte, consumer always ready.
        rx_ready = 1'b1;
        clear_counts();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(8);
        check("a5_valid_cycles", 32'(valid_cyc), 32'd1);
        check("a5_handshakes",   32'(hs_cnt),    32'd1);
        check("a5_frame_err",    32'(ferr_cnt),  32'd0);
        check("a5_busy_seen",    32'(busy_seen != 0), 32'd1);
        check("a5_busy_after",   {31'h0, rx_busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
        check("a5_parity_err",   32'(perr_cnt),  32'd0);
`endif

        // Start-bit glitch.
        clear_counts();
        pin = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        check("glitch_busy_seen", 32'(busy_seen != 0), 32'd1);
        check("glitch_busy_after", {31'h0, rx_busy}, 32'd0);
        check("glitch_activity", 32'(valid_cyc + ferr_cnt + ovr_cnt), 32'd0);

        // Bad stop bit followed by a held-low line, then a good frame.
        clear_counts();
        send_frame(8'h3C, 1'b0);
        pin = 1'b0;
        repeat (40) @(negedge clk);
        idle(16);
        check("break_frame_err", 32'(ferr_cnt),  32'd1);
        check("break_valid",     32'(valid_cyc), 32'd0);
        check("break_busy_after", {31'h0, rx_busy}, 32'd0);
        clear_counts();
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(8);
        check("7e_handshakes", 32'(hs_cnt),   32'd1);
        check("7e_frame_err",  32'(ferr_cnt), 32'd0);

        // Overrun: consumer stalled across two back-to-back frames.
        rx_ready = 1'b0;
        clear_counts();
        send_frame(8'h11, 1'b1);
        check("ovr_first_valid", {31'h0, rx_valid}, 32'd1);
        check("ovr_first_data",  {24'h0, rx_data},  32'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h22, 1'b1);
        idle(4);
        check("ovr_pulses",      32'(ovr_cnt),      32'd1);
        check("ovr_second_valid", {31'h0, rx_valid}, 32'd1);
        check("ovr_second_data", {24'h0, rx_data},  32'h22);
        rx_ready = 1'b1;
        idle(3);
        check("ovr_valid_cleared", {31'h0, rx_valid}, 32'd0);
        check("ovr_handshakes",  32'(hs_cnt),       32'd1);

        // Reset in the middle of a frame.
        clear_counts();
        pin = 1'b0;
        repeat (CPB) @(negedge clk);
        pin = 1'b1;
        repeat (36) @(negedge clk);
        check("rst_busy_midframe", {31'h0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {20'h0, rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy}, 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(30);
        clear_counts();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(8);
        check("post_rst_handshakes", 32'(hs_cnt),   32'd1);
        check("post_rst_frame_err",  32'(ferr_cnt), 32'd0);

`ifdef UART_RX_PARITY_EN
        // Wrong even parity: byte still delivered, error pulse alongside valid.
        clear_counts();
        exp_q.push_back(8'h03);
        send_frame_par(8'h03, 1'b1);
        idle(8);
        check("par_err_pulses",     32'(perr_cnt),       32'd1);
        check("par_err_with_valid", 32'(perr_valid_cnt), 32'd1);
        check("par_handshakes",     32'(hs_cnt),         32'd1);
`endif

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
